// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the stack multiply/divide unit
package muldiv_pkg;
    typedef enum logic [1:0] {MUL = 2'd0, MULHU = 2'd1, DIVU = 2'd2, MODU = 2'd3} op_t;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int MULDIV_WIDTH = 16;
    localparam int MULDIV_CNT_W = $clog2(MULDIV_WIDTH);
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring divide iteration on a shared adder
module muldiv_step #(
    parameter int WIDTH = 16
) (
    input  logic               div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   m,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0]   x;
    logic [WIDTH:0]   y;
    logic [WIDTH+1:0] s;
    // Multiply adds the multiplicand into the high half; divide subtracts the divisor from the shifted remainder
    always_comb begin
        x = div ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} : {1'b0, acc[2*WIDTH-1:WIDTH]};
        y = div ? ~{1'b0, m} : (acc[0] ? {1'b0, m} : '0);
        s = {1'b0, x} + {1'b0, y} + (WIDTH+2)'(div);
        acc_next = div ? (s[WIDTH+1] ? {s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                     : {x[WIDTH-1:0], acc[WIDTH-2:0], 1'b0})
                       : {s[WIDTH:0], acc[WIDTH-1:1]};
    end
endmodule

// File: rtl/stack_muldiv.sv
// stack_muldiv: iterative unsigned MUL/MULHU/DIVU/MODU unit fed by the operand stack
module stack_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  op_t              op,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);
    localparam int CYCLES = WIDTH;
    localparam int CNT_W  = $clog2(WIDTH);
    state_t             state, state_d;
    op_t                op_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   m_q;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic               last, div_op;
    assign last   = cnt == CNT_W'(CYCLES - 1);
    assign div_op = op_q == DIVU || op_q == MODU;
    assign busy   = state == RUN;
    assign done   = state == DONE;
    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div      (div_op),
        .acc      (acc),
        .m        (m_q),
        .acc_next (acc_next)
    );
    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end
    // Next state: start is only honoured outside RUN
    always_comb begin
        state_d = state;
        state_d = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end
    // Operand latch, iteration and result capture on the final iteration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= MUL;
            cnt      <= '0;
            m_q      <= '0;
            acc      <= '0;
            result   <= '0;
            div_zero <= 1'b0;
        end else if (state != RUN && start) begin
            op_q <= op;
            cnt  <= '0;
            m_q  <= (op == DIVU || op == MODU) ? data0 : data1;
            acc  <= {{WIDTH{1'b0}}, (op == DIVU || op == MODU) ? data1 : data0};
        end else if (state == RUN) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
                result   <= (op_q == MULHU || op_q == MODU) ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
                div_zero <= div_op && m_q == '0;
            end
        end
    end
endmodule

// File: tb/tb_stack_muldiv.sv
// tb_stack_muldiv: scoreboard bench for the stack multiply/divide unit
module tb_stack_muldiv;
    import muldiv_pkg::*;
    typedef struct {
        logic [15:0] res;
        logic        dz;
        int          cyc;
        string       name;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    op_t         op = MUL;
    logic [15:0] data0 = '0;
    logic [15:0] data1 = '0;
    logic        busy, done, div_zero;
    logic [15:0] result;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    stack_muldiv #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .data0    (data0),
        .data1    (data1),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, 32'(result), 32'(e.res));
                chk({e.name, "_div_zero"}, 32'(div_zero), 32'(e.dz));
                chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
                chk({e.name, "_busy_low"}, 32'(busy), 32'(0));
            end
        end
    end
    // Drive one start pulse at a negedge and record its expectation
    task automatic issue(input string name, input op_t o, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic dz);
        @(negedge clk);
        start = 1'b1;
        op = o;
        data1 = a;
        data0 = b;
        sb.push_back('{res: res, dz: dz, cyc: cyc + 17, name: name});
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'(0));
            sb.delete();
        end
    endtask
    initial begin
        start = 1'b1;
        op = DIVU;
        data1 = 16'h1234;
        data0 = 16'h0001;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_result", 32'(result), 32'(0));
        chk("reset_div_zero", 32'(div_zero), 32'(0));
        start = 1'b0;
        rst = 1'b1;
        issue("mul_1234", MUL, 16'h1234, 16'h0010, 16'h2340, 1'b0);
        drain();
        issue("mulhu_1234", MULHU, 16'h1234, 16'h0010, 16'h0001, 1'b0);
        drain();
        issue("mul_ffff", MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);
        drain();
        issue("mulhu_ffff", MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0);
        drain();
        issue("divu_1000_7", DIVU, 16'h03E8, 16'h0007, 16'h008E, 1'b0);
        drain();
        issue("modu_1000_7", MODU, 16'h03E8, 16'h0007, 16'h0006, 1'b0);
        drain();
        issue("divu_zero", DIVU, 16'hCAFE, 16'h0000, 16'hFFFF, 1'b1);
        drain();
        issue("modu_zero", MODU, 16'hCAFE, 16'h0000, 16'hCAFE, 1'b1);
        drain();
        issue("mul_ignore_restart", MUL, 16'h0003, 16'h0005, 16'h000F, 1'b0);
        repeat (4) @(negedge clk);
        chk("busy_in_run", 32'(busy), 32'(1));
        start = 1'b1;
        op = DIVU;
        data1 = 16'h0100;
        data0 = 16'h0002;
        @(negedge clk);
        start = 1'b0;
        chk("result_held_in_run", 32'(result), 32'h0000CAFE);
        drain();
        issue("modu_b2b_first", MODU, 16'h0064, 16'h000A, 16'h0000, 1'b0);
        begin
            int k = 0;
            while (!done && k < 40) begin
                @(negedge clk);
                k++;
            end
            chk("b2b_first_done_seen", 32'(done), 32'(1));
        end
        start = 1'b1;
        op = MUL;
        data1 = 16'h00FF;
        data0 = 16'h0101;
        sb.push_back('{res: 16'hFFFF, dz: 1'b0, cyc: cyc + 17, name: "mul_b2b_second"});
        @(negedge clk);
        start = 1'b0;
        drain();
        issue("mul_aborted", MUL, 16'h1111, 16'h0002, 16'h2222, 1'b0);
        void'(sb.pop_back());
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_result", 32'(result), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(done), 32'(0));
        issue("divu_after_abort", DIVU, 16'h0100, 16'h0010, 16'h0010, 1'b0);
        drain();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
